mult_pipe_sched: RTL and testbench
==================================

Name: mult_pipe_sched

Overview:
- Issue scheduler and sequencer for the 5-stage multiply pipeline (M1..M5).
- Tracks in-flight multiply ops in shadow valid/dst/regwrite registers.
- Drives per-stage write enables and tells decode when an instruction may issue.
- Stalls on RAW/WAW hazards against in-flight multiply destinations, and on writeback-port collisions between the single-cycle ALU path and the multiply path.

Parameters:
REG_ADDR, 5, register address width
DEPTH, 5, multiply pipeline stages (index 0..DEPTH-1), >= 2
ALU_LAT, 2, cycles from ALU-op acceptance to its writeback cycle, 1 <= ALU_LAT < DEPTH
CNT_W, 3, width of in-flight counter, must hold DEPTH

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
issue_valid  input  1  decode presents an instruction
issue_is_mult  input  1  instruction is a multiply
issue_regwrite  input  1  instruction writes a register
issue_dst  input  REG_ADDR  destination register
issue_src_a  input  REG_ADDR  source A
issue_src_b  input  REG_ADDR  source B
src_a_used  input  1  source A is read
src_b_used  input  1  source B is read
freeze  input  1  global pipeline freeze (memory stall)
issue_ready  output  1  combinational; instruction accepted when issue_valid & issue_ready
stage_we  output  DEPTH  per-stage write enable for M1..Mn
mult_wb_valid  output  1  multiply result occupies writeback this cycle
wb_sel  output  1  writeback mux: 1 = multiply path, 0 = ALU path
inflight  output  CNT_W  registered count of valid stage entries
busy  output  1  inflight != 0

Behaviour:
- State: v[k], rw[k], dst[k] for k = 0..DEPTH-1, plus the inflight counter.
- Reset: all v/rw/dst = 0, inflight = 0.
  - issue_ready = 0 and stage_we = 0 while reset is high.
  - Reset mid-operation discards all in-flight ops; no writeback is signalled afterwards.
- accept = issue_valid & issue_ready; macc = accept & issue_is_mult.
- issue_ready = !reset & !freeze & !haz & !wbc, where:
  - haz: any v[k] & rw[k] & dst[k] != 0 whose dst[k] equals either:
    - issue_src_a (if src_a_used) or issue_src_b (if src_b_used) — RAW; or
    - issue_dst (if issue_regwrite) — WAW.
  - No bypass: stage DEPTH-1 still counts.
  - wbc: !issue_is_mult & issue_regwrite & v[DEPTH-1-ALU_LAT] & rw[DEPTH-1-ALU_LAT]. The ALU op would reach writeback in the same cycle the multiply completes.
- Advance, when !freeze, at each posedge:
  - v[0] <= macc; rw[0], dst[0] <= issue_regwrite, issue_dst.
  - v[k] <= v[k-1]; rw/dst shift likewise. The entry leaving stage DEPTH-1 is retired.
  - When freeze = 1, all state holds.
- stage_we[0] = !freeze & (macc | v[0]); stage_we[k] = !freeze & (v[k-1] | v[k]).
  - Bubbles are written through so stage regwrite outputs clear.
  - Idle stages stay un-enabled.
- mult_wb_valid = v[DEPTH-1] & rw[DEPTH-1] & !freeze; wb_sel = v[DEPTH-1] & rw[DEPTH-1].
- Latency: a multiply accepted in cycle t is in stage k during cycle t+1+k and writes back in cycle t+DEPTH.
- inflight: registered.
  - +1 on macc, -1 when v[DEPTH-1] retires (!freeze); both together leave it unchanged.
  - Never exceeds DEPTH.
  - Consistent with popcount(v) every cycle (bench assertion).
- Back-to-back multiplies to independent registers issue every cycle; the pipeline is fully occupied at inflight = DEPTH.
- Non-writing ops (issue_regwrite = 0) never create wbc; a non-writing multiply never creates haz.
- dst = 0 never causes a hazard.

Test Plan:
- Reset then idle 10 cycles -> inflight = 0, busy = 0, stage_we = 0, issue_ready = 1 for a valid independent op.
- Mult dst = r5 accepted cycle 0 -> stage_we[k] high in cycle k (stage 0 also cycle 0) and k+1; mult_wb_valid = 1 and wb_sel = 1 only in cycle 5; inflight 1 in cycles 1..5, 0 in cycle 6.
- Mult dst = r5 cycle 0, then add src_a = r5 held valid -> issue_ready = 0 cycles 1..5, accepted cycle 6. Same with issue_dst = r5 (WAW) -> identical timing. src = r0 case -> accepted cycle 1.
- Mult cycle 0, independent ALU op with regwrite presented cycle 3 -> issue_ready = 0 in cycle 3, accepted cycle 4. Same ALU op with issue_regwrite = 0 -> accepted cycle 3.
- Five independent mults cycles 0..4 -> inflight = 5 at cycle 5. freeze = 1 during cycles 6..7 -> state holds, stage_we = 0, mult_wb_valid = 0. Completions then occur cycles 5, 8, 9, 10, 11.
- Three mults in flight, reset asserted 1 cycle -> next cycle inflight = 0, stage_we = 0, no mult_wb_valid ever observed for discarded ops.

Source files
------------

// File: rtl/mult_pipe_sched.sv
// Issue scheduler for the multiply pipeline: shadows in-flight multiply ops,
// stalls decode on register hazards and writeback-port collisions.
module mult_pipe_sched #(
    parameter int REG_ADDR = 5,
    parameter int DEPTH    = 5,
    parameter int ALU_LAT  = 2,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_is_mult,
    input  logic                issue_regwrite,
    input  logic [REG_ADDR-1:0] issue_dst,
    input  logic [REG_ADDR-1:0] issue_src_a,
    input  logic [REG_ADDR-1:0] issue_src_b,
    input  logic                src_a_used,
    input  logic                src_b_used,
    input  logic                freeze,
    output logic                issue_ready,
    output logic [DEPTH-1:0]    stage_we,
    output logic                mult_wb_valid,
    output logic                wb_sel,
    output logic [CNT_W-1:0]    inflight,
    output logic                busy
);

    // Stage whose op completes in the same cycle a newly accepted ALU op writes back
    localparam int WBC_IDX = DEPTH - 1 - ALU_LAT;

    logic [DEPTH-1:0]    v_q, v_d;
    logic [DEPTH-1:0]    rw_q, rw_d;
    logic [REG_ADDR-1:0] dst_q [DEPTH];
    logic [REG_ADDR-1:0] dst_d [DEPTH];
    logic [CNT_W-1:0]    inflight_q, inflight_d;

    logic haz;
    logic wbc;
    logic accept;
    logic macc;
    logic retire;

    always_comb begin
        haz = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (v_q[k] && rw_q[k] && (dst_q[k] != '0)) begin
                if ((src_a_used && (dst_q[k] == issue_src_a)) ||
                    (src_b_used && (dst_q[k] == issue_src_b)) ||
                    (issue_regwrite && (dst_q[k] == issue_dst))) begin
                    haz = 1'b1;
                end
            end
        end
    end

    assign wbc         = !issue_is_mult && issue_regwrite && v_q[WBC_IDX] && rw_q[WBC_IDX];
    assign issue_ready = !reset && !freeze && !haz && !wbc;
    assign accept      = issue_valid && issue_ready;
    assign macc        = accept && issue_is_mult;
    assign retire      = v_q[DEPTH-1] && !freeze;

    always_comb begin
        v_d        = v_q;
        rw_d       = rw_q;
        dst_d      = dst_q;
        inflight_d = inflight_q;
        if (!freeze) begin
            v_d        = {v_q[DEPTH-2:0], macc};
            rw_d       = {rw_q[DEPTH-2:0], issue_regwrite};
            dst_d[0]   = issue_dst;
            for (int k = 1; k < DEPTH; k++) begin
                dst_d[k] = dst_q[k-1];
            end
            inflight_d = inflight_q + CNT_W'(macc) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q        <= '0;
            rw_q       <= '0;
            inflight_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            v_q        <= v_d;
            rw_q       <= rw_d;
            dst_q      <= dst_d;
            inflight_q <= inflight_d;
        end
    end

    // Bubbles behind a valid op are still written so the stage regwrite clears
    always_comb begin
        stage_we = '0;
        if (!freeze && !reset) begin
            stage_we[0] = macc || v_q[0];
            for (int k = 1; k < DEPTH; k++) begin
                stage_we[k] = v_q[k-1] || v_q[k];
            end
        end
    end

    assign wb_sel        = v_q[DEPTH-1] && rw_q[DEPTH-1];
    assign mult_wb_valid = wb_sel && !freeze;
    assign inflight      = inflight_q;
    assign busy          = (inflight_q != '0);

endmodule

// File: tb/tb_mult_pipe_sched.sv
// Self-checking bench for mult_pipe_sched: directed vector table for the
// timing corner cases, then random traffic against an in-flight op-list model.
module tb_mult_pipe_sched;

    localparam int DEPTH   = 5;
    localparam int ALU_LAT = 2;
    localparam int WBC_IDX = DEPTH - 1 - ALU_LAT;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_is_mult, issue_regwrite;
    logic [4:0] issue_dst, issue_src_a, issue_src_b;
    logic       src_a_used, src_b_used, freeze;
    logic       issue_ready;
    logic [4:0] stage_we;
    logic       mult_wb_valid, wb_sel;
    logic [2:0] inflight;
    logic       busy;

    always #5 clk = ~clk;

    mult_pipe_sched #(
        .REG_ADDR(5), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_is_mult(issue_is_mult),
        .issue_regwrite(issue_regwrite), .issue_dst(issue_dst),
        .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
        .src_a_used(src_a_used), .src_b_used(src_b_used), .freeze(freeze),
        .issue_ready(issue_ready), .stage_we(stage_we),
        .mult_wb_valid(mult_wb_valid), .wb_sel(wb_sel),
        .inflight(inflight), .busy(busy)
    );

    typedef struct {
        logic       rst, valid, mult, rw;
        logic [4:0] dst, sa, sb;
        logic       ua, ub, frz;
    } in_t;

    typedef struct {
        logic       ready;
        logic [4:0] we;
        logic       wb, sel;
        int         infl;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    typedef struct {
        int         stage;
        logic [4:0] dst;
        logic       rw;
    } op_t;

    vec_t vecs[$];
    op_t  mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [4:0] single_we [7] = '{5'b00001, 5'b00011, 5'b00110, 5'b01100,
                                  5'b11000, 5'b10000, 5'b00000};

    function automatic in_t mkIn(logic rst, logic valid, logic mult, logic rw,
                                 logic [4:0] dst, logic [4:0] sa, logic ua,
                                 logic [4:0] sb, logic ub, logic frz);
        in_t s;
        s.rst = rst; s.valid = valid; s.mult = mult; s.rw = rw;
        s.dst = dst; s.sa = sa; s.ua = ua; s.sb = sb; s.ub = ub; s.frz = frz;
        return s;
    endfunction

    function automatic exp_t mkEx(logic ready, logic [4:0] we, logic wb, logic sel, int infl);
        exp_t e;
        e.ready = ready; e.we = we; e.wb = wb; e.sel = sel; e.infl = infl;
        return e;
    endfunction

    function automatic vec_t row(in_t s, exp_t e);
        vec_t r;
        r.in = s;
        r.ex = e;
        return r;
    endfunction

    function automatic in_t idleIn();
        return mkIn(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    endfunction

    function automatic in_t multIn(logic [4:0] d);
        return mkIn(0, 1, 1, 1, d, 5'd0, 0, 5'd0, 0, 0);
    endfunction

    task automatic applyStimulus(input in_t s);
        @(negedge clk);
        reset          = s.rst;
        issue_valid    = s.valid;
        issue_is_mult  = s.mult;
        issue_regwrite = s.rw;
        issue_dst      = s.dst;
        issue_src_a    = s.sa;
        issue_src_b    = s.sb;
        src_a_used     = s.ua;
        src_b_used     = s.ub;
        freeze         = s.frz;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, " issue_ready"}, 32'(issue_ready), 32'(e.ready));
        checkOutput({tag, " stage_we"}, 32'(stage_we), 32'(e.we));
        checkOutput({tag, " mult_wb_valid"}, 32'(mult_wb_valid), 32'(e.wb));
        checkOutput({tag, " wb_sel"}, 32'(wb_sel), 32'(e.sel));
        checkOutput({tag, " inflight"}, 32'(inflight), 32'(e.infl));
        checkOutput({tag, " busy"}, 32'(busy), 32'(e.infl != 0));
    endtask

    // One multiply at cycle 0 followed by an op presented from first_c onward
    task automatic addSingle(input logic [4:0] mdst, input logic mrw, input in_t fol,
                             input int first_c, input logic [6:0] mask);
        vecs.push_back(row(mkIn(0, 1, 1, mrw, mdst, 5'd0, 0, 5'd0, 0, 0),
                           mkEx(1, single_we[0], 0, 0, 0)));
        for (int c = 1; c <= 6; c++) begin
            vecs.push_back(row((c >= first_c) ? fol : idleIn(),
                               mkEx(mask[c], single_we[c], (c == 5) && mrw,
                                    (c == 5) && mrw, (c <= 5) ? 1 : 0)));
        end
    endtask

    task automatic buildTable();
        vecs.push_back(row(mkIn(1, 1, 0, 1, 5'd3, 5'd1, 1, 5'd2, 1, 0), mkEx(0, 5'b0, 0, 0, 0)));
        for (int i = 0; i < 9; i++) vecs.push_back(row(idleIn(), mkEx(1, 5'b0, 0, 0, 0)));
        vecs.push_back(row(mkIn(0, 1, 0, 1, 5'd3, 5'd1, 1, 5'd2, 1, 0), mkEx(1, 5'b0, 0, 0, 0)));

        addSingle(5'd5, 1, idleIn(), 7, 7'h7f);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 1, 5'd7, 5'd5, 1, 5'd0, 0, 0), 1, 7'b1000001);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 1, 5'd7, 5'd0, 0, 5'd5, 1, 0), 1, 7'b1000001);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 1, 5'd5, 5'd1, 1, 5'd2, 1, 0), 1, 7'b1000001);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 0, 5'd0, 5'd5, 0, 5'd5, 0, 0), 1, 7'h7f);
        addSingle(5'd0, 1, mkIn(0, 1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0), 1, 7'h7f);
        addSingle(5'd5, 0, mkIn(0, 1, 0, 1, 5'd7, 5'd5, 1, 5'd0, 0, 0), 1, 7'h7f);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 1, 5'd7, 5'd1, 1, 5'd2, 1, 0), 3, 7'b1110111);
        addSingle(5'd5, 1, mkIn(0, 1, 0, 0, 5'd7, 5'd1, 1, 5'd2, 1, 0), 3, 7'h7f);

        vecs.push_back(row(multIn(5'd1), mkEx(1, 5'b00001, 0, 0, 0)));
        vecs.push_back(row(multIn(5'd2), mkEx(1, 5'b00011, 0, 0, 1)));
        vecs.push_back(row(multIn(5'd3), mkEx(1, 5'b00111, 0, 0, 2)));
        vecs.push_back(row(multIn(5'd4), mkEx(1, 5'b01111, 0, 0, 3)));
        vecs.push_back(row(multIn(5'd5), mkEx(1, 5'b11111, 0, 0, 4)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b11111, 1, 1, 5)));
        vecs.push_back(row(mkIn(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1), mkEx(0, 5'b00000, 0, 1, 4)));
        vecs.push_back(row(mkIn(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1), mkEx(0, 5'b00000, 0, 1, 4)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b11110, 1, 1, 4)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b11100, 1, 1, 3)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b11000, 1, 1, 2)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b10000, 1, 1, 1)));
        vecs.push_back(row(idleIn(), mkEx(1, 5'b00000, 0, 0, 0)));

        vecs.push_back(row(multIn(5'd1), mkEx(1, 5'b00001, 0, 0, 0)));
        vecs.push_back(row(multIn(5'd2), mkEx(1, 5'b00011, 0, 0, 1)));
        vecs.push_back(row(multIn(5'd3), mkEx(1, 5'b00111, 0, 0, 2)));
        vecs.push_back(row(mkIn(1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0), mkEx(0, 5'b00000, 0, 0, 3)));
        for (int i = 0; i < 7; i++) vecs.push_back(row(idleIn(), mkEx(1, 5'b0, 0, 0, 0)));
    endtask

    // Reference: list of in-flight ops, each knowing which stage it occupies
    function automatic exp_t modelExpect(input in_t s, output logic macc);
        exp_t e;
        logic haz  = 1'b0;
        logic wbc  = 1'b0;
        logic tail = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].rw && mq[i].dst != 5'd0 &&
                ((s.ua && mq[i].dst == s.sa) || (s.ub && mq[i].dst == s.sb) ||
                 (s.rw && mq[i].dst == s.dst))) haz = 1'b1;
            if (mq[i].rw && mq[i].stage == WBC_IDX && !s.mult && s.rw) wbc = 1'b1;
            if (mq[i].rw && mq[i].stage == DEPTH - 1) tail = 1'b1;
        end
        e.ready = !s.rst && !s.frz && !haz && !wbc;
        macc    = s.valid && e.ready && s.mult;
        e.we    = '0;
        if (!s.frz && !s.rst) begin
            if (macc) e.we[0] = 1'b1;
            foreach (mq[i]) begin
                e.we[mq[i].stage] = 1'b1;
                if (mq[i].stage < DEPTH - 1) e.we[mq[i].stage + 1] = 1'b1;
            end
        end
        e.wb   = tail && !s.frz;
        e.sel  = tail;
        e.infl = mq.size();
        return e;
    endfunction

    task automatic modelAdvance(input in_t s, input logic macc);
        op_t nq[$];
        op_t o;
        if (s.rst) begin
            mq.delete();
        end else if (!s.frz) begin
            foreach (mq[i]) begin
                if (mq[i].stage < DEPTH - 1) begin
                    o = mq[i];
                    o.stage++;
                    nq.push_back(o);
                end
            end
            if (macc) begin
                o.stage = 0;
                o.dst   = s.dst;
                o.rw    = s.rw;
                nq.push_back(o);
            end
            mq = nq;
        end
    endtask

    function automatic in_t randIn(int i);
        in_t s;
        s.rst   = (i == 0) || ($urandom_range(0, 49) == 0);
        s.valid = ($urandom_range(0, 9) < 7);
        s.mult  = ($urandom_range(0, 1) == 1);
        s.rw    = ($urandom_range(0, 4) != 0);
        s.dst   = 5'($urandom_range(0, 7));
        s.sa    = 5'($urandom_range(0, 7));
        s.sb    = 5'($urandom_range(0, 7));
        s.ua    = ($urandom_range(0, 1) == 1);
        s.ub    = ($urandom_range(0, 1) == 1);
        s.frz   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    initial begin
        in_t  s;
        exp_t e;
        logic macc;

        reset = 1'b1; issue_valid = 1'b0; issue_is_mult = 1'b0; issue_regwrite = 1'b0;
        issue_dst = '0; issue_src_a = '0; issue_src_b = '0;
        src_a_used = 1'b0; src_b_used = 1'b0; freeze = 1'b0;
        repeat (3) @(posedge clk);

        buildTable();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            checkAll($sformatf("vec%0d", i), vecs[i].ex);
        end

        for (int i = 0; i < 600; i++) begin
            s = randIn(i);
            applyStimulus(s);
            e = modelExpect(s, macc);
            checkAll($sformatf("rand%0d", i), e);
            modelAdvance(s, macc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
